// File: rtl/codec_init_sequencer_if.sv
// Command/status bundle between codec_init_sequencer (master side) and the i2c_master
// byte engine (slave side).
interface codec_init_sequencer_if;
    logic       i2c_start;
    logic       i2c_write;
    logic       i2c_end;
    logic       i2c_read;
    logic [7:0] i2c_out;
    logic       i2c_ready;
    logic       i2c_error;

    modport master (
        output i2c_start, i2c_write, i2c_end, i2c_read, i2c_out,
        input  i2c_ready, i2c_error
    );

    modport slave (
        input  i2c_start, i2c_write, i2c_end, i2c_read, i2c_out,
        output i2c_ready, i2c_error
    );
endinterface

// File: rtl/codec_init_sequencer.sv
// Table-driven codec register loader: expands each {reg,data} entry into START/WRITE x3/END
// commands for i2c_master, with optional post-write delay and NACK retry.
//
// state | meaning
// IDLE  | waiting for go after reset
// ISSUE | waiting for i2c_ready, then fires one command strobe
// WAIT  | waiting for the master to finish the command just issued
// DELAY | post-write settle time for entries flagged in delay_mask
// DONE  | all entries written, waiting for go
// FAIL  | an entry ran out of retries, waiting for go
module codec_init_sequencer #(
    parameter int         NUM_REGS     = 11,
    parameter logic [6:0] DEVICE_ADDR  = 7'h1A,
    parameter int         DELAY_CYCLES = 50,
    parameter int         MAX_RETRIES  = 3,
    parameter int         IDX_W        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    go,
    input  logic [16*NUM_REGS-1:0]  table_data,
    input  logic [NUM_REGS-1:0]     delay_mask,
    codec_init_sequencer_if.master  i2c,
    output logic                    busy,
    output logic                    done,
    output logic                    failed,
    output logic [IDX_W-1:0]        cur_index
);

    localparam int RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int DLY_W = $clog2(DELAY_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DELAY, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [2:0] {
        ST_START, ST_ADDR, ST_REG, ST_DATA, ST_END
    } step_t;

    state_t            state, state_n;
    step_t             step, step_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [RTY_W-1:0]  rty, rty_n;
    logic [DLY_W-1:0]  dcnt, dcnt_n;
    logic              err_pend, err_n;
    logic              wait_armed;

    logic [15:0]       entry;
    logic              entry_delay;
    logic              last_entry;
    logic              advance;
    logic              cmd_start, cmd_write, cmd_end;
    logic [7:0]        out_byte;

    always_comb begin
        entry       = 16'h0000;
        entry_delay = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (IDX_W'(k) == idx) begin
                entry       = table_data[16*k +: 16];
                entry_delay = delay_mask[k];
            end
        end
    end

    assign last_entry = (idx == IDX_W'(NUM_REGS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            step       <= ST_START;
            idx        <= '0;
            rty        <= '0;
            dcnt       <= '0;
            err_pend   <= 1'b0;
            wait_armed <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            idx        <= idx_n;
            rty        <= rty_n;
            dcnt       <= dcnt_n;
            err_pend   <= err_n;
            // the master may still show the previous ready in the first WAIT cycle
            wait_armed <= (state == S_WAIT);
        end
    end

    always_comb begin
        state_n   = state;
        step_n    = step;
        idx_n     = idx;
        rty_n     = rty;
        dcnt_n    = dcnt;
        err_n     = err_pend;
        advance   = 1'b0;
        cmd_start = 1'b0;
        cmd_write = 1'b0;
        cmd_end   = 1'b0;
        out_byte  = 8'h00;

        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (go) begin
                    idx_n   = '0;
                    rty_n   = '0;
                    step_n  = ST_START;
                    err_n   = 1'b0;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (step)
                    ST_ADDR: out_byte = {DEVICE_ADDR, 1'b0};
                    ST_REG:  out_byte = entry[15:8];
                    ST_DATA: out_byte = entry[7:0];
                    default: out_byte = 8'h00;
                endcase
                if (i2c.i2c_ready) begin
                    cmd_start = (step == ST_START);
                    cmd_end   = (step == ST_END);
                    cmd_write = !cmd_start && !cmd_end;
                    state_n   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_armed && i2c.i2c_ready) begin
                    if (i2c.i2c_error && (step inside {ST_ADDR, ST_REG, ST_DATA})) begin
                        step_n  = ST_END;
                        err_n   = 1'b1;
                        state_n = S_ISSUE;
                    end else if (step != ST_END) begin
                        step_n  = step_t'(step + 3'd1);
                        state_n = S_ISSUE;
                    end else if (err_pend) begin
                        err_n = 1'b0;
                        if (int'(rty) < MAX_RETRIES) begin
                            rty_n   = rty + RTY_W'(1);
                            step_n  = ST_START;
                            state_n = S_ISSUE;
                        end else begin
                            state_n = S_FAIL;
                        end
                    end else if (entry_delay) begin
                        dcnt_n  = '0;
                        state_n = S_DELAY;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (dcnt == DLY_W'(DELAY_CYCLES - 1)) begin
                    advance = 1'b1;
                end else begin
                    dcnt_n = dcnt + DLY_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (advance) begin
            if (last_entry) begin
                state_n = S_DONE;
            end else begin
                idx_n   = idx + IDX_W'(1);
                rty_n   = '0;
                step_n  = ST_START;
                state_n = S_ISSUE;
            end
        end
    end

    assign i2c.i2c_start = cmd_start;
    assign i2c.i2c_write = cmd_write;
    assign i2c.i2c_end   = cmd_end;
    assign i2c.i2c_read  = 1'b0;
    assign i2c.i2c_out   = out_byte;

    assign busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DELAY);
    assign done      = (state == S_DONE);
    assign failed    = (state == S_FAIL);
    assign cur_index = idx;

endmodule
